// File: rtl/ppu_requant_pack.sv
// Requantizes signed partial sums from the PE array to offset-binary uint8 and
// packs four bytes little-endian per output word, with byte-enables on short tails.
module ppu_requant_pack #(
  parameter int DATA_BITS  = 32,
  parameter int SCALE_BITS = 16,
  parameter int SHIFT_BITS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_en,
  input  logic [SCALE_BITS-1:0]  cfg_scale,
  input  logic [SHIFT_BITS-1:0]  cfg_shift,
  input  logic [7:0]             cfg_zero_point,
  input  logic                   cfg_relu,
  output logic                   cfg_busy,
  input  logic [DATA_BITS-1:0]   psum_in,
  input  logic                   psum_valid,
  input  logic                   psum_last,
  output logic                   psum_ready,
  output logic [DATA_BITS-1:0]   out_data,
  output logic [DATA_BITS/8-1:0] out_byte_en,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int LANES  = DATA_BITS / 8;
  localparam int CNT_W  = $clog2(LANES);
  localparam int PROD_W = DATA_BITS + SCALE_BITS;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(127);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-128);

  // Round half up: bias by half an LSB of the result before the arithmetic shift.
  function automatic logic signed [PROD_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] x,
    input logic [SHIFT_BITS-1:0]    sh
  );
    logic signed [PROD_W-1:0] bias;
    if (sh == '0) return x;
    bias = {{(PROD_W-1){1'b0}}, 1'b1} << (sh - 1'b1);
    return (x + bias) >>> sh;
  endfunction

  function automatic logic [7:0] sat_u8(input logic signed [PROD_W-1:0] v);
    logic [7:0] s;
    if (v > SAT_MAX)      s = 8'h7F;
    else if (v < SAT_MIN) s = 8'h80;
    else                  s = v[7:0];
    return s ^ 8'h80;
  endfunction

  function automatic logic [7:0] requant(
    input logic signed [PROD_W-1:0] prod,
    input logic [SHIFT_BITS-1:0]    sh,
    input logic signed [7:0]        zp,
    input logic                     relu
  );
    logic signed [PROD_W-1:0] v;
    v = round_shift(prod, sh) + $signed({{(PROD_W-8){zp[7]}}, zp});
    if (relu && v[PROD_W-1]) v = '0;
    return sat_u8(v);
  endfunction

  logic signed [SCALE_BITS-1:0] scale_r;
  logic [SHIFT_BITS-1:0]        shift_r;
  logic signed [7:0]            zp_r;
  logic                         relu_r;

  logic                         stall;
  logic signed [PROD_W-1:0]     psum_ext, scale_ext, prod_d;

  logic                         vld_p1, last_p1;
  logic signed [PROD_W-1:0]     prod_p1;
  logic                         vld_p2, last_p2;
  logic [7:0]                   byte_p2;

  logic [CNT_W-1:0]             cnt;
  logic [DATA_BITS-1:0]         pack_buf, pack_nxt;
  logic [LANES-1:0]             be_nxt;
  logic                         word_done;

  assign stall      = out_valid & ~out_ready;
  assign psum_ready = ~stall;
  assign cfg_busy   = vld_p1 | vld_p2 | (cnt != '0) | out_valid;

  assign psum_ext  = {{SCALE_BITS{psum_in[DATA_BITS-1]}}, psum_in};
  assign scale_ext = {{DATA_BITS{scale_r[SCALE_BITS-1]}}, scale_r};
  assign prod_d    = psum_ext * scale_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scale_r <= '0;
      shift_r <= '0;
      zp_r    <= '0;
      relu_r  <= 1'b0;
    end else if (cfg_en && !cfg_busy) begin
      scale_r <= cfg_scale;
      shift_r <= cfg_shift;
      zp_r    <= cfg_zero_point;
      relu_r  <= cfg_relu;
    end
  end

  // Stage p1: multiply by scale
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      prod_p1 <= '0;
    end else if (!stall) begin
      vld_p1  <= psum_valid;
      last_p1 <= psum_last;
      prod_p1 <= prod_d;
    end
  end

  // Stage p2: round, shift, zero point, relu, saturate, offset-binary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      byte_p2 <= '0;
    end else if (!stall) begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      byte_p2 <= requant(prod_p1, shift_r, zp_r, relu_r);
    end
  end

  always_comb begin
    pack_nxt = pack_buf;
    pack_nxt[{cnt, 3'b000} +: 8] = byte_p2;
    be_nxt = '0;
    for (int i = 0; i < LANES; i++) be_nxt[i] = (i <= int'(cnt));
    word_done = last_p2 || (cnt == CNT_W'(LANES - 1));
  end

  // Packer: when not stalled, out_valid is either clear or being accepted,
  // so its next value is simply whether a word completes this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      pack_buf    <= '0;
      out_data    <= '0;
      out_byte_en <= '0;
      out_valid   <= 1'b0;
    end else if (!stall) begin
      out_valid <= vld_p2 & word_done;
      if (vld_p2) begin
        if (word_done) begin
          out_data    <= pack_nxt;
          out_byte_en <= be_nxt;
          pack_buf    <= '0;
          cnt         <= '0;
        end else begin
          pack_buf <= pack_nxt;
          cnt      <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ppu_requant_pack.sv
// Directed bench for ppu_requant_pack: table of single-word tiles plus
// hand sequences for backpressure, config-while-busy and async reset.
module tb_ppu_requant_pack;
  logic        clk;
  logic        rst;
  logic        cfg_en;
  logic [15:0] cfg_scale;
  logic [4:0]  cfg_shift;
  logic [7:0]  cfg_zero_point;
  logic        cfg_relu;
  logic        cfg_busy;
  logic [31:0] psum_in;
  logic        psum_valid;
  logic        psum_last;
  logic        psum_ready;
  logic [31:0] out_data;
  logic [3:0]  out_byte_en;
  logic        out_valid;
  logic        out_ready;

  ppu_requant_pack dut (
    .clk(clk), .rst(rst),
    .cfg_en(cfg_en), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
    .cfg_zero_point(cfg_zero_point), .cfg_relu(cfg_relu), .cfg_busy(cfg_busy),
    .psum_in(psum_in), .psum_valid(psum_valid), .psum_last(psum_last),
    .psum_ready(psum_ready),
    .out_data(out_data), .out_byte_en(out_byte_en), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0]      scale;
    logic [4:0]       shift;
    logic [7:0]       zp;
    logic             relu;
    logic [2:0]       n;
    logic [3:0][31:0] ps;
    logic [31:0]      exp_data;
    logic [3:0]       exp_be;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  int n_chk  = 0;
  int n_pass = 0;
  logic [35:0] q[$];

  // Words leave the DUT on the next rising edge when valid and ready at the falling edge.
  always @(negedge clk)
    if (rst && out_valid && out_ready) q.push_back({out_byte_en, out_data});

  function automatic vec_t mk(int scale, int shift, int zp, int relu, int n,
                              int p0, int p1, int p2, int p3,
                              logic [31:0] ed, logic [3:0] eb);
    vec_t v;
    v.scale = 16'(scale);
    v.shift = 5'(shift);
    v.zp    = 8'(zp);
    v.relu  = relu[0];
    v.n     = 3'(n);
    v.ps[0] = p0; v.ps[1] = p1; v.ps[2] = p2; v.ps[3] = p3;
    v.exp_data = ed;
    v.exp_be   = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic timeout_fail(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cfg_busy && k < 100) begin @(posedge clk); #1; k++; end
    if (cfg_busy) timeout_fail("wait_idle");
  endtask

  task automatic load_cfg(input logic [15:0] sc, input logic [4:0] sh,
                          input logic [7:0] zp, input logic relu);
    cfg_scale = sc; cfg_shift = sh; cfg_zero_point = zp; cfg_relu = relu;
    cfg_en = 1'b1;
    @(posedge clk); #1;
    cfg_en = 1'b0;
  endtask

  // Holds the psum until an edge with psum_ready=1; returns just after that edge.
  task automatic send(input logic [31:0] d, input logic last);
    int k = 0;
    logic acc;
    psum_in = d; psum_last = last; psum_valid = 1'b1;
    do begin
      @(negedge clk); acc = psum_ready;
      @(posedge clk); #1; k++;
    end while (!acc && k < 200);
    if (!acc) timeout_fail("send");
  endtask

  task automatic idle_src();
    psum_valid = 1'b0; psum_last = 1'b0;
  endtask

  task automatic get_word(input string nm, output logic [35:0] w);
    int k = 0;
    #1;
    while (q.size() == 0 && k < 40) begin @(negedge clk); #1; k++; end
    if (q.size() == 0) begin timeout_fail(nm); w = '0; end
    else w = q.pop_front();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [35:0] w;
    int lat;
    int k;
    vec_t v;

    vecs[0] = mk( 1, 0,   0, 0, 4,   5,  300, -300,   -5, 32'h7B00FF85, 4'hF);
    vecs[1] = mk( 3, 2,   0, 0, 2,   7,   -7,    0,    0, 32'h00007B85, 4'h3);
    vecs[2] = mk( 1, 0,  -3, 1, 3,  -5,    2,  200,    0, 32'h00FF8080, 4'h7);
    vecs[3] = mk( 1, 0,   0, 0, 1,   0,    0,    0,    0, 32'h00000080, 4'h1);
    vecs[4] = mk( 1, 8,   0, 0, 4, 384, -384,  383, -385, 32'h7E817F82, 4'hF);
    vecs[5] = mk(-2, 1,   0, 0, 3,  10,  -10,    3,    0, 32'h007D8A76, 4'h7);
    vecs[6] = mk( 1, 0, 127, 0, 2,   1, -200,    0,    0, 32'h000037FF, 4'h3);

    rst = 1'b0; cfg_en = 1'b0; cfg_scale = '0; cfg_shift = '0;
    cfg_zero_point = '0; cfg_relu = 1'b0;
    psum_in = '0; psum_valid = 1'b0; psum_last = 1'b0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_byte_en", 32'(out_byte_en), 32'h0);
    chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rel_psum_ready", 32'(psum_ready), 32'd1);

    for (int vi = 0; vi < NV; vi++) begin
      v = vecs[vi];
      wait_idle();
      load_cfg(v.scale, v.shift, v.zp, v.relu);
      q.delete();
      for (int j = 0; j < int'(v.n); j++) send(v.ps[j], j == int'(v.n) - 1);
      idle_src();
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
      chk($sformatf("v%0d_latency", vi), 32'(lat), 32'd2);
      get_word($sformatf("v%0d_word", vi), w);
      chk($sformatf("v%0d_data", vi), w[31:0], v.exp_data);
      chk($sformatf("v%0d_byte_en", vi), 32'(w[35:32]), 32'(v.exp_be));
      repeat (4) @(negedge clk);
      #1;
      chk($sformatf("v%0d_no_extra", vi), 32'(q.size()), 32'd0);
    end

    // Backpressure: first word held for 5 cycles with out_ready low
    wait_idle();
    load_cfg(16'd1, 5'd0, 8'd0, 1'b0);
    q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
        idle_src();
      end
      begin
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 100) begin @(negedge clk); k++; end
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        chk("bp_ready_low", 32'(psum_ready), 32'd0);
        repeat (5) @(negedge clk);
        chk("bp_hold_data", out_data, 32'h84838281);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_ready", 32'(psum_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    get_word("bp_w0", w);
    chk("bp_w0_data", w[31:0], 32'h84838281);
    chk("bp_w0_be", 32'(w[35:32]), 32'hF);
    get_word("bp_w1", w);
    chk("bp_w1_data", w[31:0], 32'h88878685);
    chk("bp_w1_be", 32'(w[35:32]), 32'hF);
    repeat (4) @(negedge clk);
    #1;
    chk("bp_no_extra", 32'(q.size()), 32'd0);

    // Config pulse while busy is ignored; once idle it takes effect
    wait_idle();
    load_cfg(16'd1, 5'd0, 8'd0, 1'b0);
    q.delete();
    send(32'd10, 1'b0);
    send(32'd20, 1'b0);
    chk("cfg_busy_mid", 32'(cfg_busy), 32'd1);
    cfg_scale = 16'd2; cfg_en = 1'b1;
    send(32'd30, 1'b0);
    cfg_en = 1'b0;
    send(32'd40, 1'b1);
    idle_src();
    get_word("cfg_w0", w);
    chk("cfg_ignored_data", w[31:0], 32'hA89E948A);
    wait_idle();
    load_cfg(16'd2, 5'd0, 8'd0, 1'b0);
    send(32'd10, 1'b1);
    idle_src();
    get_word("cfg_w1", w);
    chk("cfg_applied_data", w[31:0], 32'h00000094);
    chk("cfg_applied_be", 32'(w[35:32]), 32'h1);

    // Async reset with a partial word in flight
    wait_idle();
    load_cfg(16'd1, 5'd0, 8'd0, 1'b0);
    q.delete();
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    idle_src();
    @(posedge clk); #3;
    chk("ar_busy_before", 32'(cfg_busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_cfg_busy", 32'(cfg_busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("ar_psum_ready", 32'(psum_ready), 32'd1);
    load_cfg(16'd1, 5'd0, 8'd0, 1'b0);
    for (int i = 1; i <= 4; i++) send(32'(i), i == 4);
    idle_src();
    get_word("ar_word", w);
    chk("ar_data", w[31:0], 32'h84838281);
    chk("ar_be", 32'(w[35:32]), 32'hF);
    repeat (4) @(negedge clk);
    #1;
    chk("ar_no_extra", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ppu_requant_pack.md
Name: ppu_requant_pack

Overview:
Post-processing unit directly downstream of the SUPER PE array opsum port.
- Accepts 32-bit signed partial sums one per handshake.
- Requantizes each sum to int8: multiply by scale, rounding right shift, add zero point, optional ReLU, saturate.
- Converts each result to the array's offset-binary uint8 convention (XOR 0x80).
- Packs four bytes little-endian into a 32-bit word for the ofmap writeback buffer, with byte-enables for partial final words.

Parameters:
DATA_BITS, 32, psum input and packed output width
SCALE_BITS, 16, signed requant multiplier width
SHIFT_BITS, 5, requant right-shift amount width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
cfg_en  input  1  load config; sampled only while cfg_busy=0
cfg_scale  input  16  signed multiplier
cfg_shift  input  5  arithmetic right shift amount, 0..31
cfg_zero_point  input  8  signed int8 offset added after shift
cfg_relu  input  1  1 = clamp negatives to zero before saturation
cfg_busy  output  1  1 while any pipeline stage or packer holds data
psum_in  input  32  signed partial sum from PE opsum
psum_valid  input  1  psum_in valid
psum_last  input  1  marks final psum of the tile; flushes the packer
psum_ready  output  1  accept
out_data  output  32  packed uint8 bytes; lane0 = bits[7:0] = oldest
out_byte_en  output  4  valid lanes of out_data
out_valid  output  1  out_data valid
out_ready  input  1  downstream accept

Behaviour:
Reset (rst=0, async):
- All config registers, stage valids, packer count and data, and outputs clear to 0.
- Exception: psum_ready=1 after reset release.
- Reset mid-operation discards all in-flight data; no partial word is emitted.

Config:
- Registers load on a clk edge with cfg_en=1 and cfg_busy=0.
- cfg_en while busy is ignored.
- Config is stable for all data in flight.

Handshake:
- Transfer occurs on an edge where valid&ready=1.
- stall = out_valid & ~out_ready.
- psum_ready = ~stall.
- All pipeline stages hold while stall=1.
- out_data, out_byte_en and out_valid stay stable until accepted.

Pipeline, 2 register stages plus packer:
- S1 (edge of acceptance): prod = psum_in * cfg_scale, signed 48-bit. psum_last is carried along.
- S2: if shift=0, r = prod; else r = (prod + (1<<(shift-1))) >>> shift (round half up, arithmetic). Then v = r + sign-extended zero point, in 48-bit. If relu and v<0, v=0. Saturate v to [-128,127]. byte = v[7:0] ^ 0x80.
- Packer (next edge): writes byte into lane cnt and increments cnt.
  - If cnt reaches 4, or the byte carries last: capture word, set out_byte_en to ones in lanes 0..cnt-1, assert out_valid, reset cnt=0.
  - Unused lanes of a partial word are 0x00.
- Latency: psum accepted at edge t gives its byte in the packer at edge t+2. The 4th byte's word is visible with out_valid=1 after edge t+2.
- Word accepted on edge with out_ready=1: out_valid drops unless a new word completes on the same edge, in which case it is replaced back-to-back with no bubble.
- Throughput: one psum per cycle with out_ready held high.

Boundaries:
- last on the 4th byte gives one full word (byte_en=4'hF), not an extra empty word.
- last with cnt=0 gives byte_en=4'h1.
- psum_valid with psum_ready=0 is not accepted; source holds.
- cfg_busy = S1 valid | S2 valid | cnt!=0 | out_valid.

Test Plan:
1. Basic requant: scale=1, shift=0, zp=0, relu=0; psums 5, 300, -300, -5 (last on the 4th) -> one word 0x7B00FF85, byte_en=4'hF, out_valid asserted 2 edges after the 4th accept.
2. Rounding: scale=3, shift=2; psum 7 gives byte 0x85 (21+2=23, >>2=5); psum -7 gives 0x7B (-19>>>2=-5). Send 7, -7 with last -> out_data 0x00007B85, byte_en=4'h3.
3. ReLU and zero point: relu=1, zp=-3, scale=1, shift=0; psums -5, 2, 200 (last) -> bytes 0x80, 0x80 (2-3=-1 clamped to 0), 0xFF -> 0x00FF8080, byte_en=4'h7.
4. Backpressure: stream 8 psums (scale=1, shift=0, zp=0), out_ready=0 for 5 cycles after the first word -> psum_ready drops while stalled; both words are delivered intact in order; no byte is lost or duplicated.
5. Config while busy: pulse cfg_en with scale=2 mid-stream -> ignored; outputs match scale=1. Pulse again once cfg_busy=0 -> scale=2 takes effect.
6. Async reset mid-word: accept 2 psums, drive rst=0 between edges -> out_valid=0, cfg_busy=0 immediately. After release, a fresh 4-psum stream yields only the new word.
